// File: rtl/pll_ce_pkg.sv
// pll_ce_pkg: shared constants for the clock-enable scheduler.
//   - lock FSM state encoding (enum plus legacy 1-bit constants)
//   - default accumulator width and reset increments
//   - lock-counter width helper
package pll_ce_pkg;

  typedef enum logic [0:0] {
    LOCKING = 1'b0,
    RUN     = 1'b1
  } pll_state_e;

  localparam logic [0:0] ST_LOCKING = LOCKING;
  localparam logic [0:0] ST_RUN     = RUN;

  localparam int unsigned PLL_ACC_W    = 10;
  localparam int unsigned PLL_INC0_DEF = 737;
  localparam int unsigned PLL_INC1_DEF = 123;
  localparam int unsigned PLL_LOCK_DEF = 16;

  // Counter must be able to hold the value LOCK_CYCLES itself.
  function automatic int unsigned lock_cnt_w(input int unsigned lock_cycles);
    return $clog2(lock_cycles + 1);
  endfunction

endpackage

// File: rtl/pll_ce_chan.sv
// pll_ce_chan: one fractional-rate channel (phase accumulator, enable,
// strobe and square-wave registers).
//   refclk   : clock
//   rst      : synchronous active-high reset
//   halt     : freeze accumulator and square wave, force strobe low
//   load     : load new increment/enable and clear the phase
//   load_inc : increment to load
//   load_en  : enable to load
//   ce       : one-cycle strobe on accumulator carry (registered)
//   clk_sq   : square wave toggling on each strobe (registered)
module pll_ce_chan
  import pll_ce_pkg::*;
#(
  parameter int unsigned             ACC_W   = PLL_ACC_W,
  parameter logic [ACC_W-1:0]        INC_RST = ACC_W'(PLL_INC0_DEF)
) (
  input  logic             refclk,
  input  logic             rst,
  input  logic             halt,
  input  logic             load,
  input  logic [ACC_W-1:0] load_inc,
  input  logic             load_en,
  output logic             ce,
  output logic             clk_sq
);

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] inc;
  logic             en;
  logic [ACC_W:0]   sum_c;

  // Carry out of the accumulator is the top bit of the widened sum.
  assign sum_c = {1'b0, acc} + {1'b0, inc};

  // Load wins over disable, disable over halt, halt over normal stepping.
  always_ff @(posedge refclk) begin
    if (rst) begin
      acc    <= '0;
      inc    <= INC_RST;
      en     <= 1'b1;
      ce     <= 1'b0;
      clk_sq <= 1'b0;
    end else if (load) begin
      acc    <= '0;
      inc    <= load_inc;
      en     <= load_en;
      ce     <= 1'b0;
      clk_sq <= 1'b0;
    end else if (!en) begin
      acc    <= '0;
      ce     <= 1'b0;
      clk_sq <= 1'b0;
    end else if (halt) begin
      ce     <= 1'b0;
    end else begin
      acc    <= sum_c[ACC_W-1:0];
      ce     <= sum_c[ACC_W];
      clk_sq <= clk_sq ^ sum_c[ACC_W];
    end
  end

endmodule

// File: rtl/pll_ce_ctrl.sv
// pll_ce_ctrl: two-channel programmable clock-enable scheduler with a
// lock sequencer and a valid/ready reprogramming port.
//   refclk    : sole clock
//   rst       : synchronous active-high reset
//   halt      : freeze both accumulators and the lock counter
//   cfg_valid : reprogram request
//   cfg_ready : request accepted on this edge when valid & ready
//   cfg_ch    : target channel
//   cfg_inc   : new increment
//   cfg_en    : new channel enable
//   ce_out    : per-channel one-cycle enable strobe
//   clk_out   : per-channel square wave
//   locked    : both channels settled
module pll_ce_ctrl
  import pll_ce_pkg::*;
#(
  parameter int unsigned      ACC_W       = PLL_ACC_W,
  parameter logic [ACC_W-1:0] INC0_DEF    = ACC_W'(PLL_INC0_DEF),
  parameter logic [ACC_W-1:0] INC1_DEF    = ACC_W'(PLL_INC1_DEF),
  parameter int unsigned      LOCK_CYCLES = PLL_LOCK_DEF
) (
  input  logic             refclk,
  input  logic             rst,
  input  logic             halt,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic             cfg_ch,
  input  logic [ACC_W-1:0] cfg_inc,
  input  logic             cfg_en,
  output logic [1:0]       ce_out,
  output logic [1:0]       clk_out,
  output logic             locked
);

  localparam int unsigned CNT_W = lock_cnt_w(LOCK_CYCLES);

  logic [0:0]       state;
  logic [0:0]       state_nxt;
  logic [CNT_W-1:0] lock_cnt;
  logic [CNT_W-1:0] lock_cnt_nxt;
  logic             locked_nxt;
  logic             accept_c;

  // Ready is masked by rst so nothing is accepted on a reset edge.
  assign cfg_ready = (state == ST_RUN) & ~rst;
  assign accept_c  = cfg_valid & cfg_ready;

  // State register.
  always_ff @(posedge refclk) begin
    if (rst) begin
      state    <= ST_LOCKING;
      lock_cnt <= '0;
      locked   <= 1'b0;
    end else begin
      state    <= state_nxt;
      lock_cnt <= lock_cnt_nxt;
      locked   <= locked_nxt;
    end
  end

  // Lock sequencer: count non-halted edges, restart on every accept.
  always_comb begin
    state_nxt    = state;
    lock_cnt_nxt = lock_cnt;
    locked_nxt   = locked;
    case (state)
      ST_LOCKING: begin
        if (!halt) begin
          if (lock_cnt == CNT_W'(LOCK_CYCLES - 1)) begin
            state_nxt    = ST_RUN;
            lock_cnt_nxt = CNT_W'(LOCK_CYCLES);
            locked_nxt   = 1'b1;
          end else begin
            lock_cnt_nxt = lock_cnt + CNT_W'(1);
          end
        end
      end
      ST_RUN: begin
        if (accept_c) begin
          state_nxt    = ST_LOCKING;
          lock_cnt_nxt = '0;
          locked_nxt   = 1'b0;
        end
      end
      default: begin
        state_nxt    = ST_LOCKING;
        lock_cnt_nxt = '0;
        locked_nxt   = 1'b0;
      end
    endcase
  end

  pll_ce_chan #(
    .ACC_W   (ACC_W),
    .INC_RST (INC0_DEF)
  ) u_ch0 (
    .refclk   (refclk),
    .rst      (rst),
    .halt     (halt),
    .load     (accept_c & ~cfg_ch),
    .load_inc (cfg_inc),
    .load_en  (cfg_en),
    .ce       (ce_out[0]),
    .clk_sq   (clk_out[0])
  );

  pll_ce_chan #(
    .ACC_W   (ACC_W),
    .INC_RST (INC1_DEF)
  ) u_ch1 (
    .refclk   (refclk),
    .rst      (rst),
    .halt     (halt),
    .load     (accept_c & cfg_ch),
    .load_inc (cfg_inc),
    .load_en  (cfg_en),
    .ce       (ce_out[1]),
    .clk_sq   (clk_out[1])
  );

endmodule

// File: tb/tb_pll_ce_ctrl.sv
// tb_pll_ce_ctrl: directed bench for pll_ce_ctrl with INC0=256, INC1=512,
// ACC_W=10, LOCK_CYCLES=16. Edge counter ek is 0 after a reset edge.
module tb_pll_ce_ctrl;

  logic       refclk = 1'b0;
  logic       rst;
  logic       halt;
  logic       cfg_valid;
  logic       cfg_ready;
  logic       cfg_ch;
  logic [9:0] cfg_inc;
  logic       cfg_en;
  logic [1:0] ce_out;
  logic [1:0] clk_out;
  logic       locked;

  int errors = 0;
  int checks = 0;
  int ek     = 0;

  typedef struct {
    logic       rst;
    logic       halt;
    logic [1:0] ce;
    logic [1:0] clk;
    logic       lk;
    logic       rdy;
  } vec_t;

  vec_t vt [0:17];

  pll_ce_ctrl #(
    .ACC_W       (10),
    .INC0_DEF    (10'd256),
    .INC1_DEF    (10'd512),
    .LOCK_CYCLES (16)
  ) dut (
    .refclk    (refclk),
    .rst       (rst),
    .halt      (halt),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_ch    (cfg_ch),
    .cfg_inc   (cfg_inc),
    .cfg_en    (cfg_en),
    .ce_out    (ce_out),
    .clk_out   (clk_out),
    .locked    (locked)
  );

  always #5 refclk = ~refclk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s edge=%0d actual=%0d expected=%0d", name, ek, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge refclk);
    #1;
    if (rst) ek = 0;
    else ek++;
  endtask

  task automatic run_to(input int n);
    while (ek < n) tick();
  endtask

  initial begin
    int n_ok0, n_bad0, n_ce1, n_lk_early, n_stuck, n_rdy;

    rst = 1'b1; halt = 1'b0; cfg_valid = 1'b0;
    cfg_ch = 1'b0; cfg_inc = '0; cfg_en = 1'b0;

    // Power-up sequence: {rst, halt, ce{1,0}, clk{1,0}, locked, ready}
    vt[0]  = '{1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0};
    vt[1]  = '{1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0};
    vt[2]  = '{1'b0, 1'b0, 2'b10, 2'b10, 1'b0, 1'b0};
    vt[3]  = '{1'b0, 1'b0, 2'b00, 2'b10, 1'b0, 1'b0};
    vt[4]  = '{1'b0, 1'b0, 2'b11, 2'b01, 1'b0, 1'b0};
    vt[5]  = '{1'b0, 1'b0, 2'b00, 2'b01, 1'b0, 1'b0};
    vt[6]  = '{1'b0, 1'b0, 2'b10, 2'b11, 1'b0, 1'b0};
    vt[7]  = '{1'b0, 1'b0, 2'b00, 2'b11, 1'b0, 1'b0};
    vt[8]  = '{1'b0, 1'b0, 2'b11, 2'b00, 1'b0, 1'b0};
    vt[9]  = '{1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0};
    vt[10] = '{1'b0, 1'b0, 2'b10, 2'b10, 1'b0, 1'b0};
    vt[11] = '{1'b0, 1'b0, 2'b00, 2'b10, 1'b0, 1'b0};
    vt[12] = '{1'b0, 1'b0, 2'b11, 2'b01, 1'b0, 1'b0};
    vt[13] = '{1'b0, 1'b0, 2'b00, 2'b01, 1'b0, 1'b0};
    vt[14] = '{1'b0, 1'b0, 2'b10, 2'b11, 1'b0, 1'b0};
    vt[15] = '{1'b0, 1'b0, 2'b00, 2'b11, 1'b0, 1'b0};
    vt[16] = '{1'b0, 1'b0, 2'b11, 2'b00, 1'b1, 1'b1};
    vt[17] = '{1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 1'b1};

    for (int i = 0; i < 18; i++) begin
      rst  = vt[i].rst;
      halt = vt[i].halt;
      tick();
      check($sformatf("tbl%0d_ce", i),  int'(ce_out),    int'(vt[i].ce));
      check($sformatf("tbl%0d_clk", i), int'(clk_out),   int'(vt[i].clk));
      check($sformatf("tbl%0d_lk", i),  int'(locked),    int'(vt[i].lk));
      check($sformatf("tbl%0d_rdy", i), int'(cfg_ready), int'(vt[i].rdy));
    end

    // Reprogram ch1 to inc=1 at edge 40.
    run_to(39);
    cfg_valid = 1'b1; cfg_ch = 1'b1; cfg_inc = 10'd1; cfg_en = 1'b1;
    check("pre_accept_ready", int'(cfg_ready), 1);
    tick();
    cfg_valid = 1'b0;
    check("acc40_ek",     ek, 40);
    check("acc40_locked", int'(locked), 0);
    check("acc40_ready",  int'(cfg_ready), 0);
    check("acc40_ce1",    int'(ce_out[1]), 0);
    check("acc40_clk1",   int'(clk_out[1]), 0);
    check("acc40_ce0",    int'(ce_out[0]), 1);
    check("acc40_clk0",   int'(clk_out[0]), 0);

    n_ok0 = 0; n_bad0 = 0; n_ce1 = 0; n_lk_early = 0;
    while (ek < 1064) begin
      tick();
      if (ce_out[0]) begin
        if (ek % 4 == 0) n_ok0++;
        else n_bad0++;
      end
      if (ek < 1064 && ce_out[1]) n_ce1++;
      if (ek < 56 && locked) n_lk_early++;
      if (ek == 56) check("relock_56", int'(locked), 1);
    end
    check("lock_low_41_55", n_lk_early, 0);
    check("ch0_strobes",    n_ok0, 256);
    check("ch0_stray",      n_bad0, 0);
    check("ch1_early",      n_ce1, 0);
    check("ch1_first_ce",   int'(ce_out[1]), 1);
    check("ch1_first_clk",  int'(clk_out[1]), 1);
    check("ch0_phase_1064", int'(clk_out[0]), 0);

    // Disable ch0 at edge 1068 (where it would otherwise strobe).
    run_to(1067);
    cfg_valid = 1'b1; cfg_ch = 1'b0; cfg_inc = 10'd300; cfg_en = 1'b0;
    tick();
    check("dis_ce0",    int'(ce_out[0]), 0);
    check("dis_clk0",   int'(clk_out[0]), 0);
    check("dis_locked", int'(locked), 0);

    // Request held through LOCKING: re-enable ch0 at inc=512.
    cfg_inc = 10'd512; cfg_en = 1'b1;
    n_stuck = 0; n_rdy = 0;
    while (ek < 1084) begin
      if (cfg_ready) n_rdy++;
      tick();
      if (ce_out[0] || clk_out[0]) n_stuck++;
    end
    check("hold_ready_low", n_rdy, 0);
    check("dis_stuck0",     n_stuck, 0);
    check("run1084_locked", int'(locked), 1);
    check("run1084_ready",  int'(cfg_ready), 1);
    tick();
    cfg_valid = 1'b0;
    check("acc1085_locked", int'(locked), 0);
    check("acc1085_ready",  int'(cfg_ready), 0);
    tick();
    check("re_ce0_1086", int'(ce_out[0]), 0);
    tick();
    check("re_ce0_1087",  int'(ce_out[0]), 1);
    check("re_clk0_1087", int'(clk_out[0]), 1);
    tick();
    check("re_ce0_1088", int'(ce_out[0]), 0);
    tick();
    check("re_ce0_1089",  int'(ce_out[0]), 1);
    check("re_clk0_1089", int'(clk_out[0]), 0);

    // Reset from RUN; ready must drop combinationally with rst.
    run_to(1101);
    check("run1101_locked", int'(locked), 1);
    rst = 1'b1;
    #1;
    check("rst_ready_comb", int'(cfg_ready), 0);
    tick();
    rst = 1'b0;
    check("rst_ce",     int'(ce_out), 0);
    check("rst_clk",    int'(clk_out), 0);
    check("rst_locked", int'(locked), 0);

    // halt over edges 6..8 mid-LOCKING.
    while (ek < 20) begin
      halt = (ek + 1 >= 6 && ek + 1 <= 8);
      tick();
      if (ek == 2) check("def_inc_e2", int'(ce_out), 2);
      if (ek >= 6 && ek <= 8) begin
        check($sformatf("halt%0d_ce", ek),  int'(ce_out), 0);
        check($sformatf("halt%0d_clk", ek), int'(clk_out), 1);
      end
      if (ek == 9)  check("halt_e9_ce",   int'(ce_out), 2);
      if (ek == 10) check("halt_e10_ce",  int'(ce_out), 0);
      if (ek == 11) check("halt_e11_ce",  int'(ce_out), 3);
      if (ek == 11) check("halt_e11_clk", int'(clk_out), 0);
      if (ek == 18) check("halt_lock18",  int'(locked), 0);
      if (ek == 19) check("halt_lock19",  int'(locked), 1);
    end
    halt = 1'b0;

    // rst on an accept edge: the request must not take effect.
    cfg_valid = 1'b1; cfg_ch = 1'b1; cfg_inc = 10'd5; cfg_en = 1'b1;
    rst = 1'b1;
    tick();
    check("rstacc_ce",     int'(ce_out), 0);
    check("rstacc_clk",    int'(clk_out), 0);
    check("rstacc_locked", int'(locked), 0);
    check("rstacc_ready",  int'(cfg_ready), 0);
    rst = 1'b0; cfg_valid = 1'b0;
    run_to(2);
    check("rstacc_def_inc1", int'(ce_out), 2);

    // rst mid-LOCKING restarts the lock window.
    run_to(7);
    check("pre_rst_clk7", int'(clk_out), 3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midlock_clk",    int'(clk_out), 0);
    check("midlock_locked", int'(locked), 0);
    run_to(15);
    check("midlock_lk15", int'(locked), 0);
    tick();
    check("midlock_lk16", int'(locked), 1);
    check("midlock_ce16", int'(ce_out), 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
